// File: rtl/alu_pkg.sv
// Shared decode constants and the ALU operation enumeration for the integer execute unit.
// No logic beyond a small func3-to-operation helper.
package alu_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_LSW  = 3'b010;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND,
        ALU_ILLEGAL
    } alu_op_e;

    // Operation selected by func3 when func7 carries the base (non-alternate) encoding.
    function automatic alu_op_e base_op(input logic [2:0] func3);
        alu_op_e op;
        case (func3)
            F3_ADD:  op = ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = ALU_SRL;
            F3_OR:   op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_pipe_if.sv
// Issue-side and writeback-side valid/ready bundle of the integer execute unit.
// master = issue/writeback environment, slave = execute pipe.
interface alu_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 6
);
    logic             in_valid;
    logic             in_ready;
    logic [6:0]       in_opcode;
    logic [2:0]       in_func3;
    logic [6:0]       in_func7;
    logic [XLEN-1:0]  in_src1;
    logic [XLEN-1:0]  in_src2;
    logic [TAG_W-1:0] in_pd;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_pd;
    logic             out_illegal;

    modport master (
        output in_valid, in_opcode, in_func3, in_func7, in_src1, in_src2, in_pd, out_ready,
        input  in_ready, out_valid, out_result, out_pd, out_illegal
    );

    modport slave (
        input  in_valid, in_opcode, in_func3, in_func7, in_src1, in_src2, in_pd, out_ready,
        output in_ready, out_valid, out_result, out_pd, out_illegal
    );
endinterface

// File: rtl/alu_core.sv
// Combinational RV32I/RV64I ALU: decodes opcode/func3/func7 to an operation and computes it.
// Zero latency, no state; unsupported encodings and tag 0 yield a zero result.
module alu_core
    import alu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 6
) (
    input  logic [6:0]       i_opcode,
    input  logic [2:0]       i_func3,
    input  logic [6:0]       i_func7,
    input  logic [XLEN-1:0]  i_src1,
    input  logic [XLEN-1:0]  i_src2,
    input  logic [TAG_W-1:0] i_pd,
    output logic [XLEN-1:0]  o_result,
    output logic             o_illegal
);

    localparam int SH_W = $clog2(XLEN);
    // With a 64-bit datapath the shift-immediate borrows func7[0] as shamt[5].
    localparam logic [6:0] F7_IMM_MASK = (XLEN == 64) ? 7'b1111110 : 7'b1111111;

    alu_op_e         w_op;
    logic [6:0]      w_func7_imm;
    logic [SH_W-1:0] w_shamt;
    logic [XLEN-1:0] w_calc;

    assign w_func7_imm = i_func7 & F7_IMM_MASK;
    assign w_shamt     = i_src2[SH_W-1:0];

    always_comb begin
        w_op = ALU_ILLEGAL;
        case (i_opcode)
            OP_R: begin
                if (i_func7 == F7_BASE) begin
                    w_op = base_op(i_func3);
                end else if (i_func7 == F7_ALT && i_func3 == F3_ADD) begin
                    w_op = ALU_SUB;
                end else if (i_func7 == F7_ALT && i_func3 == F3_SR) begin
                    w_op = ALU_SRA;
                end
            end
            OP_IMM: begin
                case (i_func3)
                    F3_SLL: begin
                        if (w_func7_imm == F7_BASE) w_op = ALU_SLL;
                    end
                    F3_SR: begin
                        if (w_func7_imm == F7_BASE)     w_op = ALU_SRL;
                        else if (w_func7_imm == F7_ALT) w_op = ALU_SRA;
                    end
                    default: w_op = base_op(i_func3);
                endcase
            end
            OP_LOAD, OP_STORE: begin
                if (i_func3 == F3_LSW) w_op = ALU_ADD;
            end
            default: w_op = ALU_ILLEGAL;
        endcase
    end

    always_comb begin
        w_calc = '0;
        case (w_op)
            ALU_ADD:  w_calc = i_src1 + i_src2;
            ALU_SUB:  w_calc = i_src1 - i_src2;
            ALU_SLL:  w_calc = i_src1 << w_shamt;
            ALU_SLT:  w_calc = {{(XLEN-1){1'b0}}, ($signed(i_src1) < $signed(i_src2))};
            ALU_SLTU: w_calc = {{(XLEN-1){1'b0}}, (i_src1 < i_src2)};
            ALU_XOR:  w_calc = i_src1 ^ i_src2;
            ALU_SRL:  w_calc = i_src1 >> w_shamt;
            ALU_SRA:  w_calc = $unsigned($signed(i_src1) >>> w_shamt);
            ALU_OR:   w_calc = i_src1 | i_src2;
            ALU_AND:  w_calc = i_src1 & i_src2;
            default:  w_calc = '0;
        endcase
    end

    // Tag 0 is the hardwired x0 mapping, so its result is forced to zero.
    assign o_result  = (i_pd == '0) ? '0 : w_calc;
    assign o_illegal = (w_op == ALU_ILLEGAL);

endmodule

// File: rtl/alu_pipe.sv
// Pipelined integer execute unit: ALU result, tag and illegal flag pass through STAGES registers.
// Latency STAGES cycles, 1 op/cycle; out_ready low stalls only full stages, bubbles collapse, flush drops all.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int TAG_W  = 6,
    parameter int STAGES = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      flush,
    alu_pipe_if.slave bus
);

    logic [XLEN-1:0]   w_result;
    logic              w_illegal;
    logic [STAGES-1:0] w_load;

    logic [STAGES-1:0] r_vld;
    logic [XLEN-1:0]   r_res [STAGES];
    logic [TAG_W-1:0]  r_pd  [STAGES];
    logic [STAGES-1:0] r_ill;

    alu_core #(
        .XLEN  (XLEN),
        .TAG_W (TAG_W)
    ) u_core (
        .i_opcode  (bus.in_opcode),
        .i_func3   (bus.in_func3),
        .i_func7   (bus.in_func7),
        .i_src1    (bus.in_src1),
        .i_src2    (bus.in_src2),
        .i_pd      (bus.in_pd),
        .o_result  (w_result),
        .o_illegal (w_illegal)
    );

    // Stage i may load when the output drains or any stage from i to the output is empty.
    always_comb begin
        w_load = '0;
        for (int i = 0; i < STAGES; i++) begin
            w_load[i] = bus.out_ready || !(&(r_vld | ~({STAGES{1'b1}} << i)));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld             <= '0;
            r_res[STAGES-1]   <= '0;
            r_pd[STAGES-1]    <= '0;
            r_ill[STAGES-1]   <= 1'b0;
        end else begin
            if (w_load[0]) begin
                r_vld[0] <= bus.in_valid;
                r_res[0] <= w_result;
                r_pd[0]  <= bus.in_pd;
                r_ill[0] <= w_illegal;
            end
            for (int i = 1; i < STAGES; i++) begin
                if (w_load[i]) begin
                    r_vld[i] <= r_vld[i-1];
                    r_res[i] <= r_res[i-1];
                    r_pd[i]  <= r_pd[i-1];
                    r_ill[i] <= r_ill[i-1];
                end
            end
            if (flush) begin
                r_vld <= '0;
            end
        end
    end

    assign bus.in_ready    = w_load[0] || flush;
    assign bus.out_valid   = r_vld[STAGES-1];
    assign bus.out_result  = r_res[STAGES-1];
    assign bus.out_pd      = r_pd[STAGES-1];
    assign bus.out_illegal = r_ill[STAGES-1];

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: scenario tasks drive the bus, a negedge monitor logs accepted ops (through a
// reference model) and delivered results; each task compares what it expects inline.
module tb_alu_pipe;

    localparam int XLEN   = 32;
    localparam int TAG_W  = 6;
    localparam int STAGES = 2;

    localparam logic [6:0] R   = 7'b0110011;
    localparam logic [6:0] IMM = 7'b0010011;
    localparam logic [6:0] LD  = 7'b0000011;
    localparam logic [6:0] ST  = 7'b0100011;

    typedef struct packed {
        logic [31:0] res;
        logic [5:0]  pd;
        logic        ill;
    } rec_t;

    typedef struct {
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  pd;
    } op_t;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    always #5 clk = ~clk;

    alu_pipe_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

    alu_pipe #(.XLEN(XLEN), .TAG_W(TAG_W), .STAGES(STAGES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    int   total = 0;
    int   bad   = 0;
    rec_t exp_q[$];
    rec_t got_q[$];

    // Reference: evaluate every candidate result, then choose by encoding.
    function automatic rec_t model(logic [6:0] opc, logic [2:0] f3, logic [6:0] f7,
                                   logic [31:0] a, logic [31:0] b, logic [5:0] pd);
        rec_t        r;
        logic [31:0] by_f3 [8];
        logic [31:0] sub_v, sra_v, v;
        int          sh;
        bit          legal;
        sh       = int'(b[4:0]);
        by_f3[0] = a + b;
        by_f3[1] = a << sh;
        by_f3[2] = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
        by_f3[3] = (a < b) ? 32'd1 : 32'd0;
        by_f3[4] = a ^ b;
        by_f3[5] = a >> sh;
        by_f3[6] = a | b;
        by_f3[7] = a & b;
        sub_v    = a - b;
        sra_v    = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
        legal    = 1'b1;
        v        = 32'h0;
        if (opc == R) begin
            if (f7 == 7'h00)                  v = by_f3[f3];
            else if (f7 == 7'h20 && f3 == 0)  v = sub_v;
            else if (f7 == 7'h20 && f3 == 5)  v = sra_v;
            else                              legal = 1'b0;
        end else if (opc == IMM) begin
            if (f3 == 1)                      begin if (f7 == 7'h00) v = by_f3[1]; else legal = 1'b0; end
            else if (f3 == 5 && f7 == 7'h00)  v = by_f3[5];
            else if (f3 == 5 && f7 == 7'h20)  v = sra_v;
            else if (f3 == 5)                 legal = 1'b0;
            else                              v = by_f3[f3];
        end else if ((opc == LD || opc == ST) && f3 == 2) begin
            v = a + b;
        end else begin
            legal = 1'b0;
        end
        r.res = (!legal || pd == 0) ? 32'h0 : v;
        r.pd  = pd;
        r.ill = !legal;
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst_n || flush) begin
            while (exp_q.size() > got_q.size()) void'(exp_q.pop_back());
        end else begin
            if (bus.out_valid && bus.out_ready)
                got_q.push_back({bus.out_result, bus.out_pd, bus.out_illegal});
            if (bus.in_valid && bus.in_ready)
                exp_q.push_back(model(bus.in_opcode, bus.in_func3, bus.in_func7,
                                      bus.in_src1, bus.in_src2, bus.in_pd));
        end
    end

    function automatic op_t mk(logic [6:0] opc, logic [2:0] f3, logic [6:0] f7,
                               logic [31:0] a, logic [31:0] b, logic [5:0] pd);
        op_t o;
        o.opc = opc; o.f3 = f3; o.f7 = f7; o.a = a; o.b = b; o.pd = pd;
        return o;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        int  k;
        k    = $urandom_range(0, 5);
        o.a  = $urandom;
        o.b  = $urandom;
        o.pd = 6'($urandom_range(0, 63));
        o.f3 = 3'($urandom_range(0, 7));
        o.f7 = 7'h00;
        o.opc = R;
        case (k)
            0: o.opc = R;
            1: begin o.opc = R; o.f7 = 7'h20; o.f3 = ($urandom_range(0, 1) == 1) ? 3'd0 : 3'd5; end
            2, 3: begin o.opc = IMM; o.f7 = ($urandom_range(0, 3) == 0) ? 7'h20 : 7'h00; end
            4: begin o.opc = ($urandom_range(0, 1) == 1) ? LD : ST;
                     if ($urandom_range(0, 3) != 0) o.f3 = 3'd2; end
            default: begin o.opc = 7'($urandom); o.f7 = 7'($urandom); end
        endcase
        return o;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(op_t o);
        bus.in_opcode = o.opc;
        bus.in_func3  = o.f3;
        bus.in_func7  = o.f7;
        bus.in_src1   = o.a;
        bus.in_src2   = o.b;
        bus.in_pd     = o.pd;
    endtask

    task automatic drain(output bit ok);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
            step();
            #1;
            if (!bus.out_valid && got_q.size() == exp_q.size()) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        set_op(mk(R, 0, 0, 0, 0, 0));
        repeat (2) step();
        #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", bus.out_valid); end
        total++; if (bus.out_result !== 32'h0) begin bad++; $display("FAIL rst_result got=%h want=0", bus.out_result); end
        total++; if (bus.out_pd !== 6'h0) begin bad++; $display("FAIL rst_pd got=%h want=0", bus.out_pd); end
        total++; if (bus.out_illegal !== 1'b0) begin bad++; $display("FAIL rst_illegal got=%b want=0", bus.out_illegal); end
        step();
        rst_n = 1'b1;
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b want=1", bus.in_ready); end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_add_latency();
        int lat;
        bit ok;
        exp_q.delete(); got_q.delete();
        step();
        set_op(mk(R, 0, 0, 32'd7, 32'd5, 6'd3));
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        #1;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin step(); #1; lat++; end
        total++; if (lat != STAGES) begin bad++; $display("FAIL add_latency got=%0d want=%0d", lat, STAGES); end
        total++; if (bus.out_result !== 32'd12) begin bad++; $display("FAIL add_result got=%h want=c", bus.out_result); end
        total++; if (bus.out_pd !== 6'd3) begin bad++; $display("FAIL add_pd got=%0d want=3", bus.out_pd); end
        total++; if (bus.out_illegal !== 1'b0) begin bad++; $display("FAIL add_illegal got=%b want=0", bus.out_illegal); end
        drain(ok);
        total++; if (!ok || got_q.size() != 1) begin bad++; $display("FAIL add_count got=%0d want=1", got_q.size()); end
    endtask

    task automatic test_ops();
        op_t         ops[$];
        logic [31:0] lit [5];
        bit          hs, ok;
        int          idx;
        exp_q.delete(); got_q.delete();
        ops.push_back(mk(R, 5, 7'h20, 32'h8000_0010, 32'h24, 6'd1));
        ops.push_back(mk(R, 0, 7'h20, 32'h0, 32'h1, 6'd2));
        ops.push_back(mk(R, 4, 7'h00, 32'hF0F0, 32'h0FF0, 6'd3));
        ops.push_back(mk(R, 2, 7'h00, 32'hFFFF_FFFF, 32'h1, 6'd4));
        ops.push_back(mk(R, 3, 7'h00, 32'hFFFF_FFFF, 32'h1, 6'd5));
        ops.push_back(mk(IMM, 5, 7'h20, 32'hF000_0000, 32'h404, 6'd6));
        ops.push_back(mk(LD, 2, 7'h00, 32'h1000, 32'hFFFF_FFFC, 6'd7));
        lit[0] = 32'hF800_0001; lit[1] = 32'hFFFF_FFFF; lit[2] = 32'h0000_FF00;
        lit[3] = 32'h1;         lit[4] = 32'h0;
        for (int i = 0; i < 60; i++) ops.push_back(rand_op());
        hs = 1'b0; idx = 0;
        for (int cyc = 0; cyc < 3000 && idx < ops.size(); cyc++) begin
            step();
            if (hs) idx++;
            if (idx < ops.size()) begin
                set_op(ops[idx]);
                bus.in_valid = ($urandom_range(0, 9) < 7);
            end else begin
                bus.in_valid = 1'b0;
            end
            bus.out_ready = ($urandom_range(0, 9) < 7);
            #1;
            hs = bus.in_valid && bus.in_ready;
        end
        drain(ok);
        total++; if (!ok || idx != ops.size()) begin bad++; $display("FAIL ops_sent got=%0d want=%0d", idx, ops.size()); end
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL ops_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL ops_item%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
        end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (got_q.size() <= i || got_q[i].res !== lit[i]) begin
                bad++; $display("FAIL directed%0d got=%h want=%h", i, (got_q.size() > i) ? got_q[i].res : 32'hx, lit[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        op_t  o;
        rec_t snap;
        bit   hs, have_snap, saw_full, ok;
        int   j;
        logic [11:0] imm;
        exp_q.delete(); got_q.delete();
        hs = 1'b0; have_snap = 1'b0; saw_full = 1'b0; j = 0;
        for (int cyc = 0; cyc < 100 && j < 8; cyc++) begin
            step();
            if (hs) j++;
            bus.out_ready = !(cyc >= 4 && cyc < 9);
            bus.in_valid  = (j < 8);
            imm = 12'($urandom);
            o = mk(IMM, 0, imm[11:5], $urandom, {{20{imm[11]}}, imm}, 6'(j + 1));
            set_op(o);
            #1;
            if (!bus.out_ready) begin
                if (!bus.in_ready) begin
                    saw_full = 1'b1;
                    total++;
                    if (exp_q.size() - got_q.size() != STAGES) begin
                        bad++; $display("FAIL held_ops got=%0d want=%0d", exp_q.size() - got_q.size(), STAGES);
                    end
                end
                if (bus.out_valid && !have_snap) begin
                    snap = {bus.out_result, bus.out_pd, bus.out_illegal};
                    have_snap = 1'b1;
                end else if (bus.out_valid) begin
                    total++;
                    if ({bus.out_result, bus.out_pd, bus.out_illegal} !== snap) begin
                        bad++; $display("FAIL stall_hold got=%h want=%h", {bus.out_result, bus.out_pd, bus.out_illegal}, snap);
                    end
                end
            end
            if (cyc == 9) begin
                total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL ready_rise got=%b want=1", bus.in_ready); end
            end
            hs = bus.in_valid && bus.in_ready;
        end
        total++; if (!saw_full) begin bad++; $display("FAIL in_ready_drop got=never want=seen"); end
        drain(ok);
        total++; if (!ok || got_q.size() != 8 || exp_q.size() != 8) begin
            bad++; $display("FAIL b2b_count got=%0d want=8", got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL b2b_item%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
            total++;
            if (got_q[i].pd !== 6'(i + 1)) begin bad++; $display("FAIL b2b_order%0d got=%0d want=%0d", i, got_q[i].pd, i + 1); end
        end
    endtask

    task automatic test_special();
        bit ok;
        exp_q.delete(); got_q.delete();
        bus.out_ready = 1'b1;
        step();
        set_op(mk(R, 0, 0, 32'd3, 32'd4, 6'd0));
        bus.in_valid = 1'b1;
        step();
        set_op(mk(7'b1110011, 0, 0, $urandom, $urandom, 6'd5));
        step();
        drain(ok);
        total++; if (!ok || got_q.size() != 2) begin bad++; $display("FAIL special_count got=%0d want=2", got_q.size()); end
        if (got_q.size() == 2) begin
            total++; if (got_q[0].res !== 32'h0) begin bad++; $display("FAIL pd0_result got=%h want=0", got_q[0].res); end
            total++; if (got_q[0].ill !== 1'b0) begin bad++; $display("FAIL pd0_illegal got=%b want=0", got_q[0].ill); end
            total++; if (got_q[1].res !== 32'h0) begin bad++; $display("FAIL illop_result got=%h want=0", got_q[1].res); end
            total++; if (got_q[1].ill !== 1'b1) begin bad++; $display("FAIL illop_flag got=%b want=1", got_q[1].ill); end
            total++; if (got_q[1].pd !== 6'd5) begin bad++; $display("FAIL illop_pd got=%0d want=5", got_q[1].pd); end
        end
    endtask

    task automatic test_flush();
        bit hs, full, leak, ok;
        int j;
        exp_q.delete(); got_q.delete();
        hs = 1'b0; full = 1'b0; j = 0;
        bus.out_ready = 1'b0;
        for (int c = 0; c < 20 && !full; c++) begin
            step();
            if (hs) j++;
            set_op(mk(R, 0, 0, $urandom, $urandom, 6'(10 + j)));
            bus.in_valid = 1'b1;
            #1;
            hs = bus.in_valid && bus.in_ready;
            full = !bus.in_ready;
        end
        total++; if (!full) begin bad++; $display("FAIL flush_fill got=not_full want=full"); end
        flush = 1'b1;
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL flush_in_ready got=%b want=1", bus.in_ready); end
        step();
        flush = 1'b0; bus.in_valid = 1'b0;
        #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b want=0", bus.out_valid); end
        bus.out_ready = 1'b1;
        leak = 1'b0;
        repeat (6) begin step(); #1; if (bus.out_valid) leak = 1'b1; end
        total++; if (leak || got_q.size() != 0) begin bad++; $display("FAIL flush_leak got=%0d want=0", got_q.size()); end
        step();
        set_op(mk(R, 6, 0, 32'h00F0, 32'h0F00, 6'd30));
        bus.in_valid = 1'b1;
        step();
        drain(ok);
        total++; if (!ok || got_q.size() != 1 || exp_q.size() != 1) begin bad++; $display("FAIL flush_resume got=%0d want=1", got_q.size()); end
        if (got_q.size() == 1 && exp_q.size() == 1) begin
            total++; if (got_q[0] !== exp_q[0]) begin bad++; $display("FAIL flush_item got=%h want=%h", got_q[0], exp_q[0]); end
            total++; if (got_q[0].pd !== 6'd30) begin bad++; $display("FAIL flush_tag got=%0d want=30", got_q[0].pd); end
        end
    endtask

    task automatic test_reset_mid();
        bit hs, full, ok;
        int j;
        exp_q.delete(); got_q.delete();
        hs = 1'b0; full = 1'b0; j = 0;
        bus.out_ready = 1'b0;
        for (int c = 0; c < 20 && !full; c++) begin
            step();
            if (hs) j++;
            set_op(mk(R, 0, 0, $urandom | 32'h1, 32'h1, 6'(20 + j)));
            bus.in_valid = 1'b1;
            #1;
            hs = bus.in_valid && bus.in_ready;
            full = !bus.in_ready;
        end
        total++; if (!full) begin bad++; $display("FAIL rstmid_fill got=not_full want=full"); end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; bus.in_valid = 1'b0;
        #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b want=0", bus.out_valid); end
        total++; if (bus.out_result !== 32'h0) begin bad++; $display("FAIL rstmid_result got=%h want=0", bus.out_result); end
        total++; if (bus.out_pd !== 6'h0) begin bad++; $display("FAIL rstmid_pd got=%0d want=0", bus.out_pd); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_in_ready got=%b want=1", bus.in_ready); end
        step();
        set_op(mk(R, 1, 0, 32'h1, 32'h21, 6'd40));
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        step();
        drain(ok);
        total++; if (!ok || got_q.size() != 1 || exp_q.size() != 1) begin bad++; $display("FAIL rstmid_resume got=%0d want=1", got_q.size()); end
        if (got_q.size() == 1) begin
            total++; if (got_q[0].res !== 32'h2) begin bad++; $display("FAIL rstmid_sll got=%h want=2", got_q[0].res); end
            total++; if (got_q[0].pd !== 6'd40) begin bad++; $display("FAIL rstmid_tag got=%0d want=40", got_q[0].pd); end
        end
    endtask

    initial begin
        test_reset();
        test_add_latency();
        test_ops();
        test_back_to_back();
        test_special();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, pipelined integer execute unit for the out-of-order core. Sits between issue and the writeback/CDB arbiter. Takes one decoded micro-op per cycle (operands already read from the physical register file, immediate already muxed into source 2), computes the RV32I ALU/address result, and returns it tagged with its physical destination after a configurable number of register stages. Valid/ready handshakes are used on both sides, and a flush input supports branch recovery.

## Interface
- XLEN, 32: datapath width; must be 32 or 64.
- TAG_W, 6: physical destination tag width.
- STAGES, 2: pipeline register stages, range 1..4.

- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  kill every in-flight op.
- in_valid  in  1  op offered.
- in_ready  out  1  op accepted when in_valid && in_ready.
- in_opcode  in  7  instr[6:0].
- in_func3  in  3  instr[14:12].
- in_func7  in  7  instr[31:25].
- in_src1  in  XLEN  rs1 value.
- in_src2  in  XLEN  rs2 value, or sign-extended immediate for I/S-type.
- in_pd  in  TAG_W  physical destination tag.
- out_valid  out  1  result available.
- out_ready  in  1  downstream consumes when out_valid && out_ready.
- out_result  out  XLEN  result.
- out_pd  out  TAG_W  tag of the result.
- out_illegal  out  1  op not in the supported set.

## Operation
- Supported ops:
  - R-type 0110011, func7 0000000: ADD 000, SLL 001, SLT 010, SLTU 011, XOR 100, SRL 101, OR 110, AND 111.
  - R-type 0110011, func7 0100000: SUB 000, SRA 101.
  - I-type 0010011: the same ops with src2 as the immediate; SRAI is selected by func7 0100000 with func3 101.
  - LW/SW address generation (0000011 / 0100011, func3 010): result = src1 + src2.
- Shift amount is src2[$clog2(XLEN)-1:0]. SRA is arithmetic.
- SLT/SLTU produce 1 or 0, zero-extended.
- All arithmetic is modulo 2^XLEN; no overflow flag.
- Any other opcode/func3/func7 combination: out_result = 0, out_illegal = 1, and the op still flows through and writes back.
- in_pd == 0 forces out_result = 0. out_illegal is still computed and the op still writes back.
- Compute happens combinationally on input. The result, tag and illegal flag are registered into stage 0, then shifted through stages 1..STAGES-1. Outputs are driven from the last stage.
- Each stage has a valid bit. Stage i loads when it is empty or stage i+1 (or the output handshake, for the last stage) is taking its contents. This gives full throughput with bubbles collapsing.
- in_ready = stage 0 can load this cycle. It may depend combinationally on out_ready.

## Timing
- Reset (rst_n low at a clock edge): all valid bits clear.
  - out_valid = 0, out_result = 0, out_pd = 0, out_illegal = 0.
  - in_ready = 1 from the first cycle after reset releases.
- Latency: an op accepted at edge N is presented on out_valid in the cycle following edge N+STAGES-1, i.e. STAGES cycles with no stall. Throughput is 1 op/cycle.
- Hold rule: while out_valid && !out_ready, out_result, out_pd and out_illegal stay stable. No stage overwrites an occupied stage that is not draining.
- Full pipe with out_ready low: in_ready = 0. When out_ready rises, in_ready rises in the same cycle.
- Flush: at the edge where flush = 1, all valid bits clear and any op handshaked in that same cycle is discarded. out_valid = 0 the next cycle. in_ready stays 1 during flush.
- Reset dominates flush.
- Data registers need no reset except the output-stage registers, which reset to 0.

## Structure
- Package alu_pkg holds:
  - opcode constants (OP_R, OP_IMM, OP_LOAD, OP_STORE);
  - func3/func7 constants;
  - typedef enum alu_op_e (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, ILLEGAL).
- Sub-module alu_core: purely combinational decode to alu_op_e plus the compute, parametrised by XLEN.
- alu_pipe instantiates alu_core and generates STAGES stage registers with valid/stall logic.

## Test plan
- Reset, then ADD 0110011/000/0000000, src1 = 7, src2 = 5, pd = 3, out_ready = 1 → after STAGES cycles: out_valid = 1, result = 12, out_pd = 3, illegal = 0.
- SRA, src1 = 0x8000_0010, src2 = 0x24; SUB, src1 = 0, src2 = 1; XOR, src1 = 0xF0F0, src2 = 0x0FF0 → results 0xF800_0001, 0xFFFF_FFFF, 0xFF00. SLT −1 vs 1 → 1; SLTU −1 vs 1 → 0.
- Back-to-back 8 ADDIs with out_ready held low for 5 cycles mid-stream → in_ready drops once STAGES ops are held. Outputs are stable while stalled, all 8 results arrive in order, with no loss or duplication.
- pd = 0 with ADD 3+4 → result 0, out_valid = 1. Opcode 1110011 → result 0, illegal = 1.
- Fill the pipe, then assert flush together with in_valid for one cycle → out_valid = 0 next cycle, and no flushed tag ever appears on out_pd.
- rst_n low for one cycle mid-stream with the pipe full → all outputs 0 next cycle, then normal operation resumes.
